execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute (E) stage of the Y86-64 sequential processor; sits between decode and memory.
- Computes valE with a 64-bit ALU selected by icode/ifun.
- Holds the condition-code register (ZF, SF, OF), updated only by OPq.
- Evaluates the branch/move condition Cnd for jXX and cmovXX.

Parameters:
- W, 64, datapath width (valA/valB/valC/valE).

Ports:
- clk    in   1   clock; CC updates on rising edge.
- rst    in   1   asynchronous, active-high reset of CC.
- icode  in   4   instruction code.
- ifun   in   4   function code.
- valA   in   64  operand A from decode.
- valB   in   64  operand B from decode.
- valC   in   64  immediate constant.
- valE   out  64  ALU result, combinational.
- ZF     out  1   registered zero flag.
- SF     out  1   registered sign flag.
- OF     out  1   registered overflow flag.
- Cnd    out  1   condition result, combinational from registered CC.

Behaviour:
- Clock/reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset value: ZF=1, SF=0, OF=0. Reset takes effect immediately, including mid-operation, and overrides any clock-edge update.
- valE is combinational with zero latency. Two's-complement arithmetic; wraps modulo 2^64 and carry-out is discarded.
- valE by icode:
  - 2 (rrmovq/cmovXX): valA.
  - 3 (irmovq): valC.
  - 4 (rmmovq), 5 (mrmovq): valB+valC.
  - 6 (OPq): valB OP valA, with OP = ifun 0 add, 1 sub (valB-valA), 2 and, 3 xor. ifun>3 gives valE=0.
  - 8 (call), 10 (pushq): valB-8.
  - 9 (ret), 11 (popq): valB+8.
  - All other icodes (0,1,7,12-15): valE=0.
- CC update: on rising clk with icode==6 and ifun<=3, CC loads from the OPq result. Otherwise CC holds.
  - ZF = (result==0).
  - SF = result[63].
  - OF for add = (A[63]==B[63]) && (R[63]!=B[63]).
  - OF for sub = (B[63]!=A[63]) && (R[63]!=B[63]).
  - OF for and/xor = 0.
- Flag outputs always reflect the CC register. They are never combinational from the current result, so a new OPq's flags appear after the next rising edge.
- Cnd: active only when icode is 2 or 7; otherwise 0. Computed from the current registered CC by ifun:
  - 0 always: 1.
  - 1 le: (SF^OF)|ZF.
  - 2 l: SF^OF.
  - 3 e: ZF.
  - 4 ne: !ZF.
  - 5 ge: !(SF^OF).
  - 6 g: !(SF^OF)&!ZF.
  - 7-15: 0.
- Input changes without a clock edge never alter the flags.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: IHALT=0, INOP=1, IRRMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=10, IPOPQ=11.
  - ALU function constants: ALUADD=0, ALUSUB=1, ALUAND=2, ALUXOR=3.
  - Condition constants: C_YES..C_G = 0..6.
- One sub-module, y86_alu: combinational (a, b, fn) -> (result, zf, sf, of), instantiated once. The operand mux, CC register and Cnd logic live in execute_stage.

Test Plan:
- Reset: assert rst with no clock -> ZF=1, SF=0, OF=0 immediately. Set valA=5, valB=3, valC=7, ifun=0, then sweep icode:
  - 2 -> valE=5.
  - 3 -> 7.
  - 4 -> 10; 5 -> 10.
  - 8 -> 0xFFFFFFFFFFFFFFFB; 10 -> same.
  - 9 -> 11; 11 -> 11.
  - 1 -> 0.
- OPq arithmetic, icode=6, valA=5, checking flags after each clk edge:
  - ifun=0, valB=3 -> valE=8, then ZF=0 SF=0 OF=0.
  - ifun=1, valB=3 -> valE=0xFFFFFFFFFFFFFFFE, SF=1.
  - ifun=1, valB=5 -> 0, ZF=1.
  - ifun=1, valB=7 -> 2, all flags 0.
- Logic ops, valA=5, valB=1: ifun=2 -> valE=1; ifun=3 -> valE=4, then ZF=SF=OF=0. With valA=valB=5 and ifun=3 -> valE=0, then ZF=1.
- Overflow: add valA=1, valB=0x7FFFFFFFFFFFFFFF -> valE=0x8000000000000000, then OF=1 SF=1. Sub valB=0x8000000000000000, valA=1 -> valE=0x7FFFFFFFFFFFFFFF, then OF=1 SF=0.
- Flag hold and Cnd:
  - After flags SF=1, OF=0, ZF=0, clock with icode=4 -> flags unchanged.
  - icode=7: ifun 2 -> Cnd=1; ifun 3 -> 0; ifun 1 -> 1; ifun 6 -> 0.
  - icode=4, ifun=2 -> Cnd=0.
  - Assert rst mid-sequence -> flags return to ZF=1 SF=0 OF=0 at once.

Source files
------------

// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg : shared Y86-64 encodings (icodes, ALU functions, conditions).
// Rev 1.0 : initial release.
// ---------------------------------------------------------------------------
`default_nettype none

package y86_pkg;

    localparam logic [3:0] IHALT   = 4'd0;
    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IRRMOVQ = 4'd2;
    localparam logic [3:0] IIRMOVQ = 4'd3;
    localparam logic [3:0] IRMMOVQ = 4'd4;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] IOPQ    = 4'd6;
    localparam logic [3:0] IJXX    = 4'd7;
    localparam logic [3:0] ICALL   = 4'd8;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPUSHQ  = 4'd10;
    localparam logic [3:0] IPOPQ   = 4'd11;

    localparam logic [1:0] ALUADD = 2'd0;
    localparam logic [1:0] ALUSUB = 2'd1;
    localparam logic [1:0] ALUAND = 2'd2;
    localparam logic [1:0] ALUXOR = 2'd3;

    localparam logic [3:0] C_YES = 4'd0;
    localparam logic [3:0] C_LE  = 4'd1;
    localparam logic [3:0] C_L   = 4'd2;
    localparam logic [3:0] C_E   = 4'd3;
    localparam logic [3:0] C_NE  = 4'd4;
    localparam logic [3:0] C_GE  = 4'd5;
    localparam logic [3:0] C_G   = 4'd6;

endpackage

`default_nettype wire

// File: rtl/execute_stage_if.sv
// ---------------------------------------------------------------------------
// execute_stage_if : decode-to-execute operand bus and execute results.
// Rev 1.0 : initial release.
// ---------------------------------------------------------------------------
`default_nettype none

interface execute_stage_if #(
    parameter int W = 64
);
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [W-1:0] valC;
    logic [W-1:0] valE;
    logic         ZF;
    logic         SF;
    logic         OF;
    logic         Cnd;

    modport master (
        output icode, ifun, valA, valB, valC,
        input  valE, ZF, SF, OF, Cnd
    );

    modport slave (
        input  icode, ifun, valA, valB, valC,
        output valE, ZF, SF, OF, Cnd
    );
endinterface

`default_nettype wire

// File: rtl/y86_alu.sv
// ---------------------------------------------------------------------------
// y86_alu : combinational 64-bit ALU computing b OP a with Y86 flag outputs.
// Rev 1.0 : initial release.
// ---------------------------------------------------------------------------
`default_nettype none

module y86_alu
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  wire logic [W-1:0] i_a,
    input  wire logic [W-1:0] i_b,
    input  wire logic [1:0]   i_fn,
    output logic      [W-1:0] o_result,
    output logic              o_zf,
    output logic              o_sf,
    output logic              o_of
);

    always_comb begin
        o_result = '0;
        o_of     = 1'b0;
        case (i_fn)
            ALUADD: begin
                o_result = i_b + i_a;
                o_of     = (i_a[W-1] == i_b[W-1]) && (o_result[W-1] != i_b[W-1]);
            end
            ALUSUB: begin
                o_result = i_b - i_a;
                o_of     = (i_b[W-1] != i_a[W-1]) && (o_result[W-1] != i_b[W-1]);
            end
            ALUAND:  o_result = i_b & i_a;
            ALUXOR:  o_result = i_b ^ i_a;
            default: o_result = '0;
        endcase
    end

    assign o_zf = (o_result == '0);
    assign o_sf = o_result[W-1];

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage : Y86-64 execute stage - valE mux, condition codes, Cnd.
// Rev 1.0 : initial release.
// ---------------------------------------------------------------------------
`default_nettype none

module execute_stage
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  wire logic       clk,
    input  wire logic       rst,
    execute_stage_if.slave  i_ex
);

    localparam logic [W-1:0] c_stack_step = W'(8);

    logic [W-1:0] w_alu_result;
    logic         w_alu_zf;
    logic         w_alu_sf;
    logic         w_alu_of;
    logic         w_opq_valid;
    logic [W-1:0] w_vale;
    logic         w_cnd;
    logic         r_zf;
    logic         r_sf;
    logic         r_of;

    // Only the four defined OPq functions touch the flags.
    assign w_opq_valid = (i_ex.icode == IOPQ) && (i_ex.ifun[3:2] == 2'b00);

    y86_alu #(.W(W)) u_alu (
        .i_a      (i_ex.valA),
        .i_b      (i_ex.valB),
        .i_fn     (i_ex.ifun[1:0]),
        .o_result (w_alu_result),
        .o_zf     (w_alu_zf),
        .o_sf     (w_alu_sf),
        .o_of     (w_alu_of)
    );

    always_comb begin
        w_vale = '0;
        case (i_ex.icode)
            IRRMOVQ:         w_vale = i_ex.valA;
            IIRMOVQ:         w_vale = i_ex.valC;
            IRMMOVQ,
            IMRMOVQ:         w_vale = i_ex.valB + i_ex.valC;
            IOPQ:            w_vale = w_opq_valid ? w_alu_result : '0;
            ICALL,  IPUSHQ:  w_vale = i_ex.valB - c_stack_step;
            IRET,   IPOPQ:   w_vale = i_ex.valB + c_stack_step;
            default:         w_vale = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zf <= 1'b1;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (w_opq_valid) begin
            r_zf <= w_alu_zf;
            r_sf <= w_alu_sf;
            r_of <= w_alu_of;
        end
    end

    // Condition evaluated against the stored flags, never the live ALU result.
    always_comb begin
        w_cnd = 1'b0;
        if ((i_ex.icode == IRRMOVQ) || (i_ex.icode == IJXX)) begin
            case (i_ex.ifun)
                C_YES:   w_cnd = 1'b1;
                C_LE:    w_cnd = (r_sf ^ r_of) | r_zf;
                C_L:     w_cnd = r_sf ^ r_of;
                C_E:     w_cnd = r_zf;
                C_NE:    w_cnd = ~r_zf;
                C_GE:    w_cnd = ~(r_sf ^ r_of);
                C_G:     w_cnd = ~(r_sf ^ r_of) & ~r_zf;
                default: w_cnd = 1'b0;
            endcase
        end
    end

    assign i_ex.valE = w_vale;
    assign i_ex.ZF   = r_zf;
    assign i_ex.SF   = r_sf;
    assign i_ex.OF   = r_of;
    assign i_ex.Cnd  = w_cnd;

endmodule

`default_nettype wire

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage : scoreboard bench for execute_stage against a Y86 model.
// Rev 1.0 : initial release.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_execute_stage;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    execute_stage_if #(.W(64)) ex_if ();

    execute_stage #(.W(64)) dut (
        .clk  (clk),
        .rst  (rst),
        .i_ex (ex_if)
    );

    typedef struct {
        int          id;
        logic [63:0] vale;
        logic        zf;
        logic        sf;
        logic        of;
        logic        cnd;
    } exp_t;

    exp_t q_exp[$];
    event ev_sample;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_id  = 0;

    // Architectural model of the condition-code register
    logic m_zf = 1'b1;
    logic m_sf = 1'b0;
    logic m_of = 1'b0;

    function automatic logic [63:0] ref_vale(input logic [3:0] ic, input logic [3:0] fn,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c);
        case (ic)
            4'd2:        return a;
            4'd3:        return c;
            4'd4, 4'd5:  return b + c;
            4'd6: case (fn)
                4'd0:    return b + a;
                4'd1:    return b - a;
                4'd2:    return b & a;
                4'd3:    return b ^ a;
                default: return 64'd0;
            endcase
            4'd8, 4'd10: return b - 64'd8;
            4'd9, 4'd11: return b + 64'd8;
            default:     return 64'd0;
        endcase
    endfunction

    function automatic logic ref_cnd(input logic [3:0] ic, input logic [3:0] fn,
                                     input logic zf, input logic sf, input logic of);
        logic less;
        less = (sf != of);
        if (ic != 4'd2 && ic != 4'd7) return 1'b0;
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return less || zf;
            4'd2:    return less;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !less;
            4'd6:    return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // Flags from exact signed arithmetic: overflow means the true result
    // does not fit in 64 signed bits.
    task automatic ref_cc_update(input logic [3:0] ic, input logic [3:0] fn,
                                 input logic [63:0] a, input logic [63:0] b);
        logic signed [64:0] wide;
        logic [63:0]        r;
        logic               ovf;
        if (ic != 4'd6 || fn > 4'd3) return;
        ovf = 1'b0;
        case (fn)
            4'd0: begin
                wide = $signed({b[63], b}) + $signed({a[63], a});
                r    = wide[63:0];
                ovf  = (wide[64] != wide[63]);
            end
            4'd1: begin
                wide = $signed({b[63], b}) - $signed({a[63], a});
                r    = wide[63:0];
                ovf  = (wide[64] != wide[63]);
            end
            4'd2:    r = b & a;
            default: r = b ^ a;
        endcase
        m_zf = (r == 64'd0);
        m_sf = r[63];
        m_of = ovf;
    endtask

    task automatic push_expect();
        exp_t e;
        e.id   = step_id;
        e.vale = ref_vale(ex_if.icode, ex_if.ifun, ex_if.valA, ex_if.valB, ex_if.valC);
        e.zf   = m_zf;
        e.sf   = m_sf;
        e.of   = m_of;
        e.cnd  = ref_cnd(ex_if.icode, ex_if.ifun, m_zf, m_sf, m_of);
        q_exp.push_back(e);
        step_id++;
        -> ev_sample;
    endtask

    task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        @(negedge clk);
        ex_if.icode = ic;
        ex_if.ifun  = fn;
        ex_if.valA  = a;
        ex_if.valB  = b;
        ex_if.valC  = c;
        #1;
        push_expect();
        @(posedge clk);
        if (!rst) ref_cc_update(ic, fn, a, b);
    endtask

    // Asynchronous reset between edges; optionally held across a rising edge
    // while an OPq is presented, which must not disturb the reset flags.
    task automatic do_reset(input bit hold);
        @(negedge clk);
        if (hold) begin
            ex_if.icode = 4'd6;
            ex_if.ifun  = 4'd1;
        end
        #2 rst = 1'b1;
        #1;
        m_zf = 1'b1;
        m_sf = 1'b0;
        m_of = 1'b0;
        push_expect();
        if (hold) begin
            @(posedge clk);
            #1;
            push_expect();
        end
        #1 rst = 1'b0;
    endtask

    task automatic cmp(input string name, input int id, input logic [63:0] got,
                       input logic [63:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, got, exp_v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(ev_sample);
            if (q_exp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: sample with empty queue");
            end else begin
                e = q_exp.pop_front();
                cmp("valE", e.id, ex_if.valE, e.vale);
                cmp("ZF",   e.id, {63'd0, ex_if.ZF},  {63'd0, e.zf});
                cmp("SF",   e.id, {63'd0, ex_if.SF},  {63'd0, e.sf});
                cmp("OF",   e.id, {63'd0, ex_if.OF},  {63'd0, e.of});
                cmp("Cnd",  e.id, {63'd0, ex_if.Cnd}, {63'd0, e.cnd});
            end
        end
    end

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 6))
            0:       return 64'd0;
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'hFFFF_FFFF_FFFF_FFFF;
            4:       return 64'($urandom_range(0, 16));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin : stimulus
        logic [3:0] ic;
        logic [3:0] fn;
        rst         = 1'b1;
        ex_if.icode = 4'd0;
        ex_if.ifun  = 4'd0;
        ex_if.valA  = 64'd0;
        ex_if.valB  = 64'd0;
        ex_if.valC  = 64'd0;
        #3;
        push_expect();
        #3 rst = 1'b0;

        // Operand mux sweep
        issue(4'd2,  4'd0, 64'd5, 64'd3, 64'd7);
        issue(4'd3,  4'd0, 64'd5, 64'd3, 64'd7);
        issue(4'd4,  4'd0, 64'd5, 64'd3, 64'd7);
        issue(4'd5,  4'd0, 64'd5, 64'd3, 64'd7);
        issue(4'd8,  4'd0, 64'd5, 64'd3, 64'd7);
        issue(4'd10, 4'd0, 64'd5, 64'd3, 64'd7);
        issue(4'd9,  4'd0, 64'd5, 64'd3, 64'd7);
        issue(4'd11, 4'd0, 64'd5, 64'd3, 64'd7);
        issue(4'd1,  4'd0, 64'd5, 64'd3, 64'd7);

        // OPq arithmetic and logic
        issue(4'd6, 4'd0, 64'd5, 64'd3, 64'd0);
        issue(4'd6, 4'd1, 64'd5, 64'd3, 64'd0);
        issue(4'd6, 4'd1, 64'd5, 64'd5, 64'd0);
        issue(4'd6, 4'd1, 64'd5, 64'd7, 64'd0);
        issue(4'd6, 4'd2, 64'd5, 64'd1, 64'd0);
        issue(4'd6, 4'd3, 64'd5, 64'd1, 64'd0);
        issue(4'd6, 4'd3, 64'd5, 64'd5, 64'd0);
        issue(4'd1, 4'd0, 64'd0, 64'd0, 64'd0);

        // Signed overflow
        issue(4'd6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        issue(4'd6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
        issue(4'd1, 4'd0, 64'd0, 64'd0, 64'd0);

        // Flag hold and condition evaluation
        issue(4'd6, 4'd1, 64'd5, 64'd3, 64'd0);
        issue(4'd4, 4'd0, 64'd5, 64'd3, 64'd7);
        issue(4'd7, 4'd2, 64'd0, 64'd0, 64'd0);
        issue(4'd7, 4'd3, 64'd0, 64'd0, 64'd0);
        issue(4'd7, 4'd1, 64'd0, 64'd0, 64'd0);
        issue(4'd7, 4'd6, 64'd0, 64'd0, 64'd0);
        issue(4'd4, 4'd2, 64'd0, 64'd0, 64'd0);
        do_reset(1'b0);
        issue(4'd7, 4'd3, 64'd0, 64'd0, 64'd0);
        issue(4'd6, 4'd1, 64'd5, 64'd3, 64'd0);
        do_reset(1'b1);
        issue(4'd2, 4'd4, 64'd9, 64'd0, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: begin ic = 4'd6; fn = 4'($urandom_range(0, 5)); end
                    4, 5:       begin ic = 4'd7; fn = 4'($urandom_range(0, 9)); end
                    6:          begin ic = 4'd2; fn = 4'($urandom_range(0, 9)); end
                    default:    begin ic = 4'($urandom_range(0, 15)); fn = 4'($urandom_range(0, 15)); end
                endcase
                issue(ic, fn, rnd_val(), rnd_val(), rnd_val());
            end
        end

        for (int k = 0; k < 5 && q_exp.size() != 0; k++) @(negedge clk);
        if (q_exp.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
